jtframe_sdram64_cmdarb: RTL and testbench
=========================================

Name: jtframe_sdram64_cmdarb

Overview:
SDRAM command-bus arbiter and multiplexer for the 64-bit SDRAM controller. It is the granting end of the br/bg handshake used by the refresh engine and the four bank engines. It decides which requester owns the command bus each cycle, pulses the matching grant, and drives the owner's command, address and bank onto registered SDRAM pins. Refresh has priority. Bank requests are blocked until all banks are idle so that the refresh's precharge-all is safe.

Parameters:
RFSH_GAP, 2, cycles after rfshing falls during which bank grants stay blocked (tRC margin); 0 disables the gap.
AW, 13, SDRAM address width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rfsh_br  in  1  refresh bus request
rfsh_bg  out  1  refresh grant, one-cycle pulse
rfshing  in  1  refresh engine owns the bus while high
rfsh_cmd  in  4  refresh command {/CS,/RAS,/CAS,/WE}
rfsh_a  in  AW  refresh address
bank_br  in  4  per-bank bus request
bank_bg  out  4  per-bank grant, one-hot, one-cycle pulse
bank_idle  in  4  bank has no open row and no burst in flight
bank_cmd  in  16  bank i command at [4i+3:4i]
bank_a  in  4*AW  bank i address at [AW*i +: AW]
sdram_cmd  out  4  registered SDRAM command
sdram_a  out  AW  registered SDRAM address
sdram_ba  out  2  registered SDRAM bank address

Behaviour:
- Reset (synchronous, every clk edge with rst=1):
  - sdram_cmd=NOP (4'b0111), sdram_a=0, sdram_ba=0.
  - rfsh_bg=0, bank_bg=0.
  - Round-robin pointer=0, owner-valid=0, gap counter=0, rfsh_pend=0.
  - Applies mid-operation: any in-flight grant is dropped. The next cycle after rst falls is an idle cycle.
- Grants are registered. Requests sampled at edge n produce the grant pulse during cycle n+1.
- Bank grant rules:
  - Eligible = bank_br[i] & ~bank_bg[i]. A request is ignored while its own grant is high, so no double grant.
  - Round robin: search starts at pointer. The pointer moves to (granted index+1) mod 4.
  - At most one bank grant per cycle. Back-to-back grants to different banks are allowed every cycle.
  - Blocked while any of: rfsh_pend, rfsh_bg, rfshing, or gap counter≠0.
- Bank ownership:
  - The granted bank presents its command/address in the cycle after its bank_bg pulse.
  - The arbiter keeps owner index and owner-valid, delayed one cycle from bank_bg.
- Refresh:
  - rfsh_pend sets when rfsh_br=1, rfsh_bg=0 and rfshing=0. It clears when rfsh_bg is issued.
  - rfsh_bg is issued when all of the following hold: rfsh_pend (or rfsh_br on the same cycle), &bank_idle, no bank grant in the current cycle, owner-valid=0.
  - Simultaneous rfsh_br and bank_br with all conditions met: refresh wins and no bank grant is issued.
  - While rfsh_pend, new bank grants stop, so banks drain to idle and refresh cannot starve.
- Gap: on the falling edge of rfshing, the gap counter loads RFSH_GAP and decrements to 0.
- Output mux (registered, one-cycle latency from owner input to pins):
  - rfshing=1: sdram_cmd=rfsh_cmd, sdram_a=rfsh_a, sdram_ba=0.
  - else owner-valid=1: sdram_cmd=bank_cmd[owner], sdram_a=bank_a[owner], sdram_ba=owner.
  - else: sdram_cmd=NOP. sdram_a and sdram_ba keep their last values.
- rfshing and owner-valid both high (protocol violation): refresh takes priority; the bank command is dropped.

Test Plan:
- Single bank: bank_br[2]=1 at edge 0 → bank_bg=4'b0100 in cycle 1. Bank drives READ (0101), a=0x123 in cycle 2 → sdram_cmd=0101, sdram_a=0x123, sdram_ba=2 in cycle 3. bank_bg back to 0 in cycle 2 even with br still high.
- Round robin: bank_br=4'b1111 held → bank_bg sequence 0001,0010,0100,1000,0001 on consecutive cycles, then an idle cycle after each repeat of the same bank. Pointer reset → first grant goes to bank 0.
- Refresh priority: rfsh_br=1 and bank_br=4'b0001, bank_idle=4'b1111, no prior grant → rfsh_bg=1, bank_bg=0. While rfshing=1, sdram_cmd follows rfsh_cmd (PRECHARGE 0010, then REFRESH 0001) with sdram_a=0x400, sdram_ba=0.
- Drain: bank_idle=4'b1101 and rfsh_br=1 → no rfsh_bg and no bank grants. Set bank_idle[1]=1 → rfsh_bg pulses the next cycle.
- Gap: RFSH_GAP=2, rfshing falls at edge k → bank_bg stays 0 for 2 cycles, first bank grant in cycle k+3.
- Reset mid-refresh: rst=1 while rfshing=1 → next cycle sdram_cmd=NOP, all grants 0, pointer=0. After rst release with bank_br=4'b1000 → grant 1000 after one cycle.

Source files
------------

// File: rtl/jtframe_sdram64_cmdarb.sv
// SDRAM command-bus arbiter: grants the bus to refresh or one of four bank engines
// and drives the owner's command/address/bank onto registered SDRAM pins.
module jtframe_sdram64_cmdarb #(
    parameter int unsigned RFSH_GAP = 2,
    parameter int unsigned AW       = 13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rfsh_br,
    output logic            rfsh_bg,
    input  logic            rfshing,
    input  logic [3:0]      rfsh_cmd,
    input  logic [AW-1:0]   rfsh_a,
    input  logic [3:0]      bank_br,
    output logic [3:0]      bank_bg,
    input  logic [3:0]      bank_idle,
    input  logic [15:0]     bank_cmd,
    input  logic [4*AW-1:0] bank_a,
    output logic [3:0]      sdram_cmd,
    output logic [AW-1:0]   sdram_a,
    output logic [1:0]      sdram_ba
);

    localparam int unsigned GW      = (RFSH_GAP > 1) ? $clog2(RFSH_GAP + 1) : 1;
    localparam logic [3:0]  CMD_NOP = 4'b0111;

    logic [1:0]    ptr;
    logic [1:0]    owner;
    logic          owner_valid;
    logic          rfsh_pend;
    logic [GW-1:0] gap_cnt;

    logic          rfsh_new_c;
    logic          rfsh_req_c;
    logic          rfsh_go_c;
    logic          bank_block_c;
    logic [3:0]    bank_elig_c;
    logic [3:0]    bank_go_c;
    logic [1:0]    bank_idx_c;
    logic [1:0]    slot_c;
    logic [1:0]    bg_idx_c;
    logic [3:0]    cmd_nxt_c;
    logic [AW-1:0] a_nxt_c;
    logic [1:0]    ba_nxt_c;

    // Refresh request and the conditions that hold off bank grants
    always_comb begin
        rfsh_new_c   = rfsh_br & ~rfsh_bg & ~rfshing;
        rfsh_req_c   = rfsh_pend | rfsh_new_c;
        rfsh_go_c    = rfsh_req_c & (&bank_idle) & ~(|bank_bg) & ~owner_valid;
        bank_block_c = rfsh_req_c | rfsh_bg | rfshing | (gap_cnt != '0);
    end

    // Round-robin search from ptr; descending loop so the nearest slot wins
    always_comb begin
        bank_elig_c = bank_br & ~bank_bg;
        bank_go_c   = '0;
        bank_idx_c  = ptr;
        slot_c      = ptr;
        for (int i = 3; i >= 0; i--) begin
            slot_c = ptr + 2'(i);
            if (bank_elig_c[slot_c]) bank_idx_c = slot_c;
        end
        if (!bank_block_c && bank_elig_c[bank_idx_c]) bank_go_c[bank_idx_c] = 1'b1;
    end

    // Owner select; refresh overrides a bank owner, idle keeps the last address
    always_comb begin
        bg_idx_c  = {bank_bg[3] | bank_bg[2], bank_bg[3] | bank_bg[1]};
        cmd_nxt_c = CMD_NOP;
        a_nxt_c   = sdram_a;
        ba_nxt_c  = sdram_ba;
        if (rfshing) begin
            cmd_nxt_c = rfsh_cmd;
            a_nxt_c   = rfsh_a;
            ba_nxt_c  = '0;
        end else if (owner_valid) begin
            cmd_nxt_c = bank_cmd[{owner, 2'b00} +: 4];
            a_nxt_c   = bank_a[AW*owner +: AW];
            ba_nxt_c  = owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rfsh_bg     <= 1'b0;
            bank_bg     <= '0;
            ptr         <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            rfsh_pend   <= 1'b0;
            gap_cnt     <= '0;
            sdram_cmd   <= CMD_NOP;
            sdram_a     <= '0;
            sdram_ba    <= '0;
        end else begin
            rfsh_bg     <= rfsh_go_c;
            bank_bg     <= bank_go_c;
            owner       <= bg_idx_c;
            owner_valid <= |bank_bg;
            if (|bank_go_c) ptr <= bank_idx_c + 2'd1;
            if (rfsh_go_c)       rfsh_pend <= 1'b0;
            else if (rfsh_new_c) rfsh_pend <= 1'b1;
            // Held at RFSH_GAP while refreshing, so it counts down once rfshing falls
            if (rfshing)               gap_cnt <= GW'(RFSH_GAP);
            else if (gap_cnt != '0)    gap_cnt <= gap_cnt - GW'(1);
            sdram_cmd   <= cmd_nxt_c;
            sdram_a     <= a_nxt_c;
            sdram_ba    <= ba_nxt_c;
        end
    end

endmodule

// File: tb/tb_jtframe_sdram64_cmdarb.sv
// Bench for jtframe_sdram64_cmdarb: directed scenarios with literal checks plus a
// cycle-level behavioural model compared against the pins on every cycle.
module tb_jtframe_sdram64_cmdarb;

    localparam int AW  = 13;
    localparam int GAP = 2;
    localparam logic [3:0] NOP = 4'b0111;

    logic            clk = 1'b0;
    logic            rst;
    logic            rfsh_br;
    logic            rfsh_bg;
    logic            rfshing;
    logic [3:0]      rfsh_cmd;
    logic [AW-1:0]   rfsh_a;
    logic [3:0]      bank_br;
    logic [3:0]      bank_bg;
    logic [3:0]      bank_idle;
    logic [15:0]     bank_cmd;
    logic [4*AW-1:0] bank_a;
    logic [3:0]      sdram_cmd;
    logic [AW-1:0]   sdram_a;
    logic [1:0]      sdram_ba;

    int n_cmp = 0;
    int n_bad = 0;

    jtframe_sdram64_cmdarb #(.RFSH_GAP(GAP), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rfsh_br   (rfsh_br),
        .rfsh_bg   (rfsh_bg),
        .rfshing   (rfshing),
        .rfsh_cmd  (rfsh_cmd),
        .rfsh_a    (rfsh_a),
        .bank_br   (bank_br),
        .bank_bg   (bank_bg),
        .bank_idle (bank_idle),
        .bank_cmd  (bank_cmd),
        .bank_a    (bank_a),
        .sdram_cmd (sdram_cmd),
        .sdram_a   (sdram_a),
        .sdram_ba  (sdram_ba)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the bus in each cycle, by cycle index
    int            cyc     = 0;
    int            last_rf = -1000;
    int            m_ptr   = 0;
    int            g_now   = -1;
    int            g_prev  = -1;
    int            grant;
    bit            m_pend  = 0;
    bit            m_ok    = 0;
    bit            newreq, want, rf_ok, blocked;
    logic          exp_rfsh_bg;
    logic [3:0]    exp_bank_bg;
    logic [3:0]    exp_cmd;
    logic [AW-1:0] exp_a;
    logic [1:0]    exp_ba;

    always @(negedge clk) begin
        if (m_ok) begin
            check("rfsh_bg",   32'(rfsh_bg),   32'(exp_rfsh_bg));
            check("bank_bg",   32'(bank_bg),   32'(exp_bank_bg));
            check("sdram_cmd", 32'(sdram_cmd), 32'(exp_cmd));
            check("sdram_a",   32'(sdram_a),   32'(exp_a));
            check("sdram_ba",  32'(sdram_ba),  32'(exp_ba));
        end
        cyc++;
        if (rst) begin
            exp_rfsh_bg = 1'b0;
            exp_bank_bg = 4'b0;
            exp_cmd     = NOP;
            exp_a       = '0;
            exp_ba      = 2'd0;
            m_ptr  = 0;
            m_pend = 0;
            g_now  = -1;
            g_prev = -1;
            last_rf = -1000;
            m_ok   = 1;
        end else if (m_ok) begin
            if (rfshing) last_rf = cyc;
            newreq  = rfsh_br && !exp_rfsh_bg && !rfshing;
            want    = m_pend || newreq;
            rf_ok   = want && bank_idle == 4'hf && g_now < 0 && g_prev < 0;
            blocked = want || exp_rfsh_bg || (cyc - last_rf <= GAP);
            grant   = -1;
            if (!blocked) begin
                for (int k = 0; k < 4; k++) begin
                    int b;
                    b = (m_ptr + k) % 4;
                    if (grant < 0 && bank_br[b] && b != g_now) grant = b;
                end
            end
            if (rfshing) begin
                exp_cmd = rfsh_cmd;
                exp_a   = rfsh_a;
                exp_ba  = 2'd0;
            end else if (g_prev >= 0) begin
                exp_cmd = bank_cmd[4*g_prev +: 4];
                exp_a   = bank_a[AW*g_prev +: AW];
                exp_ba  = 2'(g_prev);
            end else begin
                exp_cmd = NOP;
            end
            if (rf_ok)       m_pend = 0;
            else if (newreq) m_pend = 1;
            if (grant >= 0) m_ptr = (grant + 1) % 4;
            exp_rfsh_bg = rf_ok;
            exp_bank_bg = (grant >= 0) ? 4'(1 << grant) : 4'b0;
            g_prev = g_now;
            g_now  = grant;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rfsh_br = 1'b0; rfshing = 1'b0; rfsh_cmd = NOP; rfsh_a = '0;
        bank_br = 4'b0; bank_idle = 4'hf; bank_cmd = {4{NOP}}; bank_a = '0;
        step();
        check("reset cmd",     32'(sdram_cmd), 32'(4'b0111));
        check("reset a",       32'(sdram_a),   32'h0);
        check("reset ba",      32'(sdram_ba),  32'h0);
        check("reset bank_bg", 32'(bank_bg),   32'h0);
        check("reset rfsh_bg", 32'(rfsh_bg),   32'h0);
        rst = 1'b0;
        step();

        // Single bank 2: grant, owner cycle, pins
        bank_br = 4'b0100;
        bank_cmd[11:8] = 4'b0101;
        bank_a[AW*2 +: AW] = 13'h123;
        step();
        check("single grant", 32'(bank_bg), 32'(4'b0100));
        step();
        check("single no double", 32'(bank_bg), 32'h0);
        bank_br = 4'b0;
        step();
        check("single cmd", 32'(sdram_cmd), 32'(4'b0101));
        check("single a",   32'(sdram_a),   32'h123);
        check("single ba",  32'(sdram_ba),  32'h2);

        // Round robin from a freshly reset pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        bank_br = 4'b1111;
        step();
        check("rr 0", 32'(bank_bg), 32'(4'b0001));
        step();
        check("rr 1", 32'(bank_bg), 32'(4'b0010));
        step();
        check("rr 2", 32'(bank_bg), 32'(4'b0100));
        step();
        check("rr 3", 32'(bank_bg), 32'(4'b1000));
        step();
        check("rr wrap", 32'(bank_bg), 32'(4'b0001));
        bank_br = 4'b0;
        step();
        step();
        step();

        // Refresh beats a simultaneous bank request
        rfsh_br = 1'b1;
        bank_br = 4'b0001;
        step();
        check("prio rfsh_bg", 32'(rfsh_bg), 32'h1);
        check("prio bank_bg", 32'(bank_bg), 32'h0);
        rfsh_br = 1'b0;
        rfshing = 1'b1;
        rfsh_cmd = 4'b0010;
        rfsh_a = 13'h400;
        step();
        check("rfsh pre cmd", 32'(sdram_cmd), 32'(4'b0010));
        check("rfsh pre a",   32'(sdram_a),   32'h400);
        check("rfsh pre ba",  32'(sdram_ba),  32'h0);
        rfsh_cmd = 4'b0001;
        step();
        check("rfsh ref cmd", 32'(sdram_cmd), 32'(4'b0001));
        check("rfsh blocks bank", 32'(bank_bg), 32'h0);
        rfsh_cmd = NOP;
        step();

        // Gap: rfshing drops now, bank 0 still requesting
        rfshing = 1'b0;
        step();
        check("gap 1", 32'(bank_bg), 32'h0);
        step();
        check("gap 2", 32'(bank_bg), 32'h0);
        step();
        check("gap grant", 32'(bank_bg), 32'(4'b0001));
        bank_br = 4'b0;
        step();
        step();

        // Drain: refresh waits for all banks idle and blocks bank grants meanwhile
        bank_idle = 4'b1101;
        rfsh_br = 1'b1;
        bank_br = 4'b0010;
        step();
        check("drain rfsh_bg 0", 32'(rfsh_bg), 32'h0);
        check("drain bank_bg 0", 32'(bank_bg), 32'h0);
        rfsh_br = 1'b0;
        step();
        check("drain rfsh_bg 1", 32'(rfsh_bg), 32'h0);
        check("drain bank_bg 1", 32'(bank_bg), 32'h0);
        bank_idle = 4'hf;
        step();
        check("drain release", 32'(rfsh_bg), 32'h1);
        bank_br = 4'b0;

        // Reset in the middle of a refresh
        rfshing = 1'b1;
        rfsh_cmd = 4'b0010;
        step();
        check("mid rfsh cmd", 32'(sdram_cmd), 32'(4'b0010));
        rst = 1'b1;
        step();
        check("mid rst cmd",     32'(sdram_cmd), 32'(4'b0111));
        check("mid rst bank_bg", 32'(bank_bg),   32'h0);
        check("mid rst rfsh_bg", 32'(rfsh_bg),   32'h0);
        rst = 1'b0;
        rfshing = 1'b0;
        bank_br = 4'b1000;
        step();
        check("post rst grant", 32'(bank_bg), 32'(4'b1000));
        bank_br = 4'b0;
        step();
        step();

        // Mixed traffic, checked by the model only
        for (int n = 0; n < 300; n++) begin
            rst       = ($urandom % 97) == 0;
            rfsh_br   = ($urandom % 10) == 0;
            rfshing   = ($urandom % 7) == 0;
            rfsh_cmd  = 4'($urandom);
            rfsh_a    = AW'($urandom);
            bank_br   = 4'($urandom);
            bank_idle = (($urandom % 4) != 0) ? 4'hf : 4'($urandom);
            bank_cmd  = 16'($urandom);
            bank_a    = {AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom)};
            step();
        end
        rst = 1'b0; rfsh_br = 1'b0; rfshing = 1'b0; bank_br = 4'b0;
        step();
        step();
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
